// File: rtl/im_bist_ram.sv
// im_bist_ram: single-clock instruction memory with built-in March C- self test
// and an optional delayed-write stage that forwards pending data to reads.
module im_bist_ram #(
  parameter int DWIDTH   = 34,
  parameter int AWIDTH   = 14,
  parameter int WR_DELAY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bist_mode_i,
  input  logic [AWIDTH-1:0] addr_i,
  input  logic [DWIDTH-1:0] wdata_i,
  input  logic              wen_i,
  output logic [DWIDTH-1:0] rdata_o,
  output logic              rvalid_o,
  output logic              bist_busy_o,
  output logic              bist_finish_o,
  output logic              bist_fail_o,
  output logic [AWIDTH-1:0] bist_fail_addr_o
);
  localparam int DEPTH = 2 ** AWIDTH;
  typedef enum logic [2:0] {IDLE, M0, M1, M2, M3, M4, M5, DONE} state_t;
  state_t state, state_n;
  logic ph, ph_n, pend_v, chk, func, desc, two, last, adv, bist_rd, bist_wr, we, fwd;
  logic [AWIDTH-1:0] cnt, cnt_n, pend_a, chk_addr, wa, ra;
  logic [DWIDTH-1:0] pend_d, chk_exp, wd, rd_pat, wr_pat;
  logic [DWIDTH-1:0] mem [DEPTH];
  assign bist_busy_o = !(state inside {IDLE, DONE});
  assign bist_finish_o = state == DONE;
  // ph splits two-cycle elements into read/write halves and marks the M5 flush cycle
  always_comb begin
    func = state == IDLE;
    desc = state inside {M3, M4, M5};
    two = state inside {M1, M2, M3, M4};
    last = cnt == (desc ? '0 : '1);
    adv = two ? ph : 1'b1;
    bist_rd = state inside {M1, M2, M3, M4, M5} && !ph;
    bist_wr = state == M0 || (two && ph);
    wr_pat = state inside {M1, M3} ? '1 : '0;
    rd_pat = state inside {M2, M4} ? '1 : '0;
    we = !rst && (bist_wr || (func && wen_i && WR_DELAY == 0));
    wa = bist_wr ? cnt : addr_i;
    wd = bist_wr ? wr_pat : wdata_i;
    ra = func ? addr_i : cnt;
    fwd = func && pend_v && pend_a == addr_i;
    state_n = state;
    ph_n = 1'b0;
    cnt_n = cnt;
    if (!bist_mode_i) state_n = IDLE;
    else if (func) begin
      state_n = M0;
      cnt_n = '0;
    end else if (state == M5 && ph) state_n = DONE;
    else if (state != DONE) begin
      ph_n = two ? !ph : (state == M5 && last);
      if (adv) begin
        cnt_n = desc ? cnt - 1'b1 : cnt + 1'b1;
        if (last && state != M5) begin
          state_n = state_t'(state + 3'd1);
          cnt_n = state inside {M2, M3, M4} ? '1 : '0;
        end
      end
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ph <= 1'b0;
      cnt <= '0;
      pend_v <= 1'b0;
      chk <= 1'b0;
      rdata_o <= '0;
      rvalid_o <= 1'b0;
      bist_fail_o <= 1'b0;
      bist_fail_addr_o <= '0;
    end else begin
      state <= state_n;
      ph <= ph_n;
      cnt <= cnt_n;
      pend_v <= WR_DELAY != 0 && func && wen_i;
      chk <= bist_mode_i && bist_rd;
      rvalid_o <= func && !wen_i;
      if (func ? !wen_i : bist_rd) rdata_o <= fwd ? pend_d : mem[ra];
      if (!bist_mode_i) begin
        bist_fail_o <= 1'b0;
        bist_fail_addr_o <= '0;
      end else if (chk && !bist_fail_o && rdata_o != chk_exp) begin
        bist_fail_o <= 1'b1;
        bist_fail_addr_o <= chk_addr;
      end
    end
  end
  // the pending commit and the current write share an edge, so the array has two write ports
  always_ff @(posedge clk) begin
    if (func && wen_i) begin
      pend_a <= addr_i;
      pend_d <= wdata_i;
    end
    chk_exp <= rd_pat;
    chk_addr <= cnt;
    if (pend_v && !rst) mem[pend_a] <= pend_d;
    if (we) mem[wa] <= wd;
  end
endmodule

// File: tb/tb_im_bist_ram.sv
// tb_im_bist_ram: directed bench with a scoreboard queue for im_bist_ram
// (WR_DELAY=1 instance dut, WR_DELAY=0 instance dut0 sharing the inputs).
module tb_im_bist_ram;
  localparam int DW = 34;
  localparam int AW = 4;
  typedef struct {string tag; logic [63:0] v;} exp_t;
  logic clk = 1'b0;
  logic rst, bist_mode, wen, stuck;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic [DW-1:0] rdata, rdata0;
  logic rvalid, busy, finish, fail, rvalid0, busy0, finish0, fail0;
  logic [AW-1:0] fail_addr, fail_addr0;
  int total = 0;
  int passed = 0;
  exp_t q[$];

  im_bist_ram #(.DWIDTH(DW), .AWIDTH(AW), .WR_DELAY(1)) dut (
    .clk(clk), .rst(rst), .bist_mode_i(bist_mode), .addr_i(addr), .wdata_i(wdata),
    .wen_i(wen), .rdata_o(rdata), .rvalid_o(rvalid), .bist_busy_o(busy),
    .bist_finish_o(finish), .bist_fail_o(fail), .bist_fail_addr_o(fail_addr));

  im_bist_ram #(.DWIDTH(DW), .AWIDTH(AW), .WR_DELAY(0)) dut0 (
    .clk(clk), .rst(rst), .bist_mode_i(bist_mode), .addr_i(addr), .wdata_i(wdata),
    .wen_i(wen), .rdata_o(rdata0), .rvalid_o(rvalid0), .bist_busy_o(busy0),
    .bist_finish_o(finish0), .bist_fail_o(fail0), .bist_fail_addr_o(fail_addr0));

  always #5 clk = ~clk;

  // stuck-at-0 on bit 0 of word 7, re-imposed between active edges
  always @(negedge clk) if (stuck) dut.mem[7][0] = 1'b0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic push(string tag, logic [63:0] v);
    q.push_back('{tag, v});
  endtask

  task automatic pop(logic [63:0] obs);
    exp_t e;
    if (q.size() == 0) begin
      total++;
      $error("FAIL scoreboard_underflow observed=%0h expected=none", obs);
    end else begin
      e = q.pop_front();
      chk(e.tag, obs, e.v);
    end
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    addr = a;
    wdata = d;
    wen = 1'b1;
    step();
    wen = 1'b0;
    chk("wr_rvalid", rvalid, 0);
  endtask

  task automatic rd(input bit z, input logic [AW-1:0] a, input logic [DW-1:0] exp, input string tag);
    addr = a;
    wen = 1'b0;
    push(tag, exp);
    step();
    pop(z ? rdata0 : rdata);
    chk({tag, "_rvalid"}, z ? rvalid0 : rvalid, 1);
  endtask

  task automatic run_bist(input string tag, output int cyc, output int first_fail);
    int c;
    bist_mode = 1'b1;
    step();
    c = 1;
    first_fail = 0;
    while (busy && c < 400) begin
      if (fail && first_fail == 0) first_fail = c;
      step();
      c++;
    end
    cyc = c - 1;
  endtask

  initial begin
    int cyc, ff;
    rst = 1'b1;
    bist_mode = 1'b0;
    wen = 1'b0;
    stuck = 1'b0;
    addr = '0;
    wdata = '0;
    step();
    step();
    chk("rst_rdata", rdata, 0);
    chk("rst_rvalid", rvalid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_finish", finish, 0);
    chk("rst_fail", fail, 0);
    chk("rst_fail_addr", fail_addr, 0);
    rst = 1'b0;
    step();

    wr(4'd5, 34'h2_DEADBEEF);
    rd(1'b1, 4'd5, 34'h2_DEADBEEF, "wd0_rd5");

    wr(4'd3, 34'h1_12345678);
    rd(1'b0, 4'd3, 34'h1_12345678, "fwd_rd3");
    rd(1'b0, 4'd3, 34'h1_12345678, "ram_rd3");
    wr(4'd10, 34'h3_0F0F0F0F);
    wr(4'd11, 34'h0_A5A5A5A5);
    rd(1'b0, 4'd10, 34'h3_0F0F0F0F, "seq_rd10");
    rd(1'b0, 4'd11, 34'h0_A5A5A5A5, "seq_rd11");

    push("clean_cycles", 161);
    run_bist("clean", cyc, ff);
    pop(cyc);
    chk("clean_finish", finish, 1);
    chk("clean_fail", fail, 0);
    chk("clean_rvalid", rvalid, 0);
    step();
    step();
    chk("clean_finish_hold", finish, 1);
    bist_mode = 1'b0;
    step();
    chk("clean_finish_clr", finish, 0);
    chk("clean_busy_clr", busy, 0);

    stuck = 1'b1;
    push("fault_cycles", 161);
    push("fault_first", 65);
    run_bist("fault", cyc, ff);
    pop(cyc);
    pop(ff);
    chk("fault_finish", finish, 1);
    chk("fault_fail", fail, 1);
    chk("fault_addr", fail_addr, 7);
    chk("clean0_fail", fail0, 0);
    stuck = 1'b0;
    bist_mode = 1'b0;
    step();
    chk("fault_fail_clr", fail, 0);
    chk("fault_addr_clr", fail_addr, 0);
    chk("fault_finish_clr", finish, 0);

    bist_mode = 1'b1;
    step();
    repeat (49) step();
    chk("abort_busy_run", busy, 1);
    bist_mode = 1'b0;
    step();
    chk("abort_busy", busy, 0);
    chk("abort_finish", finish, 0);
    chk("abort_fail", fail, 0);
    wr(4'd9, 34'h0_000000AA);
    rd(1'b0, 4'd9, 34'h0_000000AA, "abort_rd9");
    rd(1'b1, 4'd9, 34'h0_000000AA, "abort0_rd9");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/im_bist_ram.md
Name: im_bist_ram

Overview:
- Parametrised instruction memory with an integrated March C- BIST controller. Next generation of the fetch-side IM block.
- Generalised in data width and depth, with an optional write-delay stage that forwards read-after-write data.
- Replaces the separate clock mux, wrapper, external BIST engine and delay stage with one self-contained, single-clock block.
- Sits between the fetch stage (address, write data, write enable) and the decode stage (instruction read data).

Parameters:
- DWIDTH, 34, instruction word width in bits.
- AWIDTH, 14, address width; DEPTH = 2**AWIDTH words.
- WR_DELAY, 1, 0 = write lands in the RAM on the capture edge; 1 = write is registered one extra cycle, with forwarding.

Ports:
- clk  in  1  the only clock; the RAM and all state use it.
- rst  in  1  synchronous, active-high reset.
- bist_mode_i  in  1  level; high requests a BIST run, low returns to functional mode.
- addr_i  in  AWIDTH  fetch read/write address.
- wdata_i  in  DWIDTH  instruction to write.
- wen_i  in  1  functional write enable.
- rdata_o  out  DWIDTH  registered read data.
- rvalid_o  out  1  rdata_o holds a functional read result.
- bist_busy_o  out  1  BIST FSM is outside IDLE/DONE.
- bist_finish_o  out  1  BIST has completed; sticky.
- bist_fail_o  out  1  miscompare seen; sticky.
- bist_fail_addr_o  out  AWIDTH  address of the first miscompare.

Behaviour:
- Reset:
  - All outputs go to 0, the FSM goes to IDLE, and the write-delay register is invalidated.
  - RAM contents are not reset.
- Functional read (FSM in IDLE, wen_i=0):
  - Address is sampled at edge k; rdata_o = mem[addr] and rvalid_o=1 after edge k+1. Latency is 1.
  - rvalid_o=0 in any cycle with no read.
- Functional write (wen_i=1):
  - No read occurs; rvalid_o=0 the next cycle.
  - WR_DELAY=0: mem[addr_i] is updated at edge k.
  - WR_DELAY=1: {addr, data} is captured at edge k into a pending register and committed at edge k+1.
- Forwarding (WR_DELAY=1):
  - If a read address equals a valid pending address, rdata_o returns the pending data, not the RAM word.
  - Consecutive writes commit in order. The commit and the following operation share the cycle, so the array is modelled dual-ported for commit.
- wen_i and addr_i are ignored while the FSM is not IDLE.
- A pending delayed write still commits on BIST entry.
- BIST FSM states and cycle counts:
  - IDLE -> M0 when bist_mode_i is sampled high.
  - M0: ascending, w0. 1 cycle per address.
  - M1: ascending, r0 then w1.
  - M2: ascending, r1 then w0.
  - M3: descending, r0 then w1.
  - M4: descending, r1 then w0.
  - M1–M4 each take 2 cycles per address: a read cycle, then a write cycle in which the read data is compared.
  - M5: descending, r0. 1 cycle per address plus 1 flush cycle for the final compare.
  - DONE follows M5.
- Patterns: "0" is all-zero DWIDTH and "1" is all-one DWIDTH.
- Address counter:
  - Ascending elements run 0 to DEPTH-1; descending elements run DEPTH-1 to 0.
  - The element advances when the counter wraps. The counter reloads 0 or DEPTH-1 on element entry.
- Run length: M0 entry to DONE takes exactly 10*DEPTH+1 cycles. bist_finish_o rises the cycle DONE is entered.
- Fail capture:
  - On the first miscompare, bist_fail_o is set and bist_fail_addr_o latches the address.
  - Later miscompares do not update the address. The test always runs to completion.
- DONE: holds finish, fail and fail address while bist_mode_i=1.
- Return to IDLE:
  - When bist_mode_i=0 from any state, the FSM goes to IDLE at the next edge and finish, fail, fail address and busy clear.
  - Aborting a run leaves RAM contents undefined.
- rdata_o during BIST: shows raw RAM read data, and rvalid_o stays 0.
- Reset mid-BIST: same effect as abort, plus the pending write is dropped.

Test Plan (DWIDTH=34, AWIDTH=4, DEPTH=16):
- Reset: assert rst for 2 cycles -> all outputs 0, bist_busy_o=0.
- Write/read: WR_DELAY=0; write 34'h2_DEADBEEF to addr 5, then read addr 5 -> next cycle rdata_o=34'h2_DEADBEEF, rvalid_o=1. The write cycle's following cycle has rvalid_o=0.
- Forwarding: WR_DELAY=1; write 34'h1_12345678 to addr 3, then read addr 3 on the immediately following cycle -> rdata_o=34'h1_12345678. A second read of addr 3 returns the same value from the RAM.
- Clean BIST: hold bist_mode_i=1 -> bist_busy_o high for 161 cycles, then bist_finish_o=1, bist_fail_o=0. Finish holds until bist_mode_i=0, and clears the next cycle.
- Fault: force mem[7] bit 0 stuck-at-0 -> bist_fail_o=1 first in M2 read of addr 7, bist_fail_addr_o=4'h7, finish still at cycle 161.
- Abort: drop bist_mode_i at cycle 50 of a run -> next cycle busy=0, finish=0, fail=0. Write/read of addr 9 with 34'h0_000000AA then returns 34'h0_000000AA.
